// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue
//   Instruction fetch front end between the PC logic and decode. Holds the
//   fetch address, issues word reads over a req/gnt/rvalid handshake, and
//   buffers returned instructions with their PCs in an in-order queue.
//   A redirect flushes the queue, marks in-flight responses for discard and
//   restarts fetch at the new (word-aligned) target.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   synchronous active-low reset
//   redirect     in   flush and restart fetch this cycle
//   redirect_pc  in   new fetch target, bits [1:0] ignored
//   imem_req     out  read request valid
//   imem_addr    out  word-aligned read address
//   imem_gnt     in   request accepted when imem_req & imem_gnt
//   imem_rvalid  in   read data valid (in request order)
//   imem_rdata   in   instruction word
//   out_valid    out  queue head valid
//   out_ready    in   decode accepts head
//   out_instr    out  head instruction (0 while empty)
//   out_pc       out  head PC (0 while empty)
module inst_fetch_queue #(
   parameter logic [31:0] RESET_PC        = 32'h0000_3000,
   parameter int unsigned DEPTH           = 4,
   parameter int unsigned MAX_OUTSTANDING = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
   localparam int unsigned SW = ((CW > OW) ? CW : OW) + 1;

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   resp_pc_q, resp_pc_d;
   logic [OW-1:0] outst_q, outst_d;
   logic [OW-1:0] drop_q, drop_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [31:0]   pc_mem_q    [DEPTH];
   logic [31:0]   instr_mem_q [DEPTH];

   logic [SW-1:0] occupancy;
   logic          credit;
   logic          grant;
   logic          discard;
   logic          push;
   logic          pop;
   logic [31:0]   target_pc;
   logic          unused_pc_bits;

   assign unused_pc_bits = ^redirect_pc[1:0];
   assign target_pc      = {redirect_pc[31:2], 2'b00};

   // Slots already claimed: queued entries plus responses that will be kept.
   assign occupancy = SW'(count_q) + SW'(outst_q) - SW'(drop_q);
   assign credit    = (occupancy < SW'(DEPTH)) && (outst_q < OW'(MAX_OUTSTANDING));

   assign imem_req  = credit & ~redirect;
   assign imem_addr = fetch_pc_q;
   assign grant     = imem_req & imem_gnt;

   // A response landing in the redirect cycle belongs to the old stream.
   assign discard   = imem_rvalid & ((drop_q != '0) | redirect);
   assign push      = imem_rvalid & ~discard;

   assign out_valid = (count_q != '0);
   assign pop       = out_valid & out_ready & ~redirect;
   assign out_instr = out_valid ? instr_mem_q[rd_ptr_q] : 32'd0;
   assign out_pc    = out_valid ? pc_mem_q[rd_ptr_q]    : 32'd0;

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      resp_pc_d  = resp_pc_q;
      outst_d    = outst_q + OW'(grant) - OW'(imem_rvalid);
      drop_d     = drop_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q + CW'(push) - CW'(pop);

      if (grant) begin
         fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (push) begin
         wr_ptr_d  = wr_ptr_q + AW'(1);
         resp_pc_d = resp_pc_q + 32'd4;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (discard && (drop_q != '0)) begin
         drop_d = drop_q - OW'(1);
      end

      // Everything still in flight is stale once the stream is redirected;
      // no grant can happen this cycle, so outstanding minus this cycle's
      // response is exactly what remains to be thrown away.
      if (redirect) begin
         fetch_pc_d = target_pc;
         resp_pc_d  = target_pc;
         drop_d     = outst_q - OW'(imem_rvalid);
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         fetch_pc_q <= RESET_PC;
         resp_pc_q  <= RESET_PC;
         outst_q    <= '0;
         drop_q     <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         outst_q    <= outst_d;
         drop_q     <= drop_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
      end
   end

   // Queue storage carries no reset; validity comes from count_q.
   always_ff @(posedge clk) begin
      if (reset && push) begin
         pc_mem_q[wr_ptr_q]    <= resp_pc_q;
         instr_mem_q[wr_ptr_q] <= imem_rdata;
      end
   end

   // Credit accounting must make a push into a full queue impossible.
   always_ff @(posedge clk) begin
      if (reset) begin
         assert (!(push && (count_q == CW'(DEPTH))));
      end
   end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Testbench for inst_fetch_queue: randomized memory/decode stimulus with an
// epoch-based reference model and a scoreboard of expected {pc, instr}.
module tb_inst_fetch_queue;

   localparam logic [31:0] RESET_PC = 32'h0000_3000;
   localparam int          DEPTH    = 4;
   localparam int          MAX_OUT  = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        out_ready = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        out_valid;
   logic [31:0] out_instr;
   logic [31:0] out_pc;

   inst_fetch_queue #(
      .RESET_PC        (RESET_PC),
      .DEPTH           (DEPTH),
      .MAX_OUTSTANDING (MAX_OUT)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_instr   (out_instr),
      .out_pc      (out_pc)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   exp_t        exp_q[$];   // scoreboard: what decode must see, in order
   logic [31:0] mem_q[$];   // memory model: granted addresses awaiting data
   int unsigned ep_q[$];    // epoch of each in-flight request
   int unsigned epoch = 0;
   logic [31:0] m_fetch = RESET_PC;
   logic [31:0] m_resp  = RESET_PC;
   int          n_checks = 0;
   int          n_fail   = 0;
   int          n_pops   = 0;
   bit          after_rst = 1'b0;
   bit          cap_first = 1'b0;
   logic [31:0] first_pc = '0;
   int unsigned gnt_pct = 100;
   int unsigned rv_pct  = 100;
   int unsigned rdy_pct = 100;
   int          mon_kept;
   bit          mon_req_exp;
   int unsigned mon_ep;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hC3A5_961E;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor / reference model: evaluates each cycle's handshakes at negedge.
   always @(negedge clk) begin
      if (!reset) begin
         exp_q.delete();
         mem_q.delete();
         ep_q.delete();
         epoch++;
         m_fetch   = RESET_PC;
         m_resp    = RESET_PC;
         after_rst = 1'b1;
         cap_first = 1'b0;
      end else begin
         mon_kept = 0;
         foreach (ep_q[i]) if (ep_q[i] == epoch) mon_kept++;
         mon_req_exp = !redirect && ((exp_q.size() + mon_kept) < DEPTH) && (ep_q.size() < MAX_OUT);
         chk("imem_req", 32'(imem_req), 32'(mon_req_exp));
         chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
         if (after_rst) begin
            chk("rst_out_pc", out_pc, 32'd0);
            chk("rst_out_instr", out_instr, 32'd0);
            chk("rst_imem_addr", imem_addr, RESET_PC);
            after_rst = 1'b0;
         end
         if (imem_req && imem_gnt) begin
            chk("imem_addr", imem_addr, m_fetch);
            mem_q.push_back(imem_addr);
            ep_q.push_back(epoch);
            m_fetch = m_fetch + 32'd4;
         end
         if (out_valid && out_ready && !redirect && exp_q.size() != 0) begin
            chk("out_pc", out_pc, exp_q[0].pc);
            chk("out_instr", out_instr, exp_q[0].instr);
            void'(exp_q.pop_front());
            n_pops++;
            if (cap_first) begin
               first_pc  = out_pc;
               cap_first = 1'b0;
            end
         end
         if (imem_rvalid && ep_q.size() != 0) begin
            mon_ep = ep_q.pop_front();
            void'(mem_q.pop_front());
            if (mon_ep == epoch && !redirect) begin
               exp_q.push_back('{m_resp, mem_word(m_resp)});
               m_resp = m_resp + 32'd4;
            end
         end
         if (redirect) begin
            exp_q.delete();
            epoch++;
            m_fetch   = {redirect_pc[31:2], 2'b00};
            m_resp    = {redirect_pc[31:2], 2'b00};
            cap_first = 1'b1;
            first_pc  = '0;
         end
      end
   end

   task automatic drive_cycle(input bit rst_n, input bit do_redir, input logic [31:0] tgt);
      @(posedge clk);
      #1;
      reset    = rst_n;
      imem_gnt = ($urandom_range(99) < gnt_pct);
      if (rst_n && mem_q.size() != 0 && ($urandom_range(99) < rv_pct)) begin
         imem_rvalid = 1'b1;
         imem_rdata  = mem_word(mem_q[0]);
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata  = $urandom;
      end
      out_ready   = ($urandom_range(99) < rdy_pct);
      redirect    = rst_n && do_redir;
      redirect_pc = do_redir ? tgt : $urandom;
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) drive_cycle(1'b1, 1'b0, 32'd0);
   endtask

   task automatic do_reset();
      drive_cycle(1'b0, 1'b0, 32'd0);
      drive_cycle(1'b0, 1'b0, 32'd0);
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   int  p0;
   bit  hit;

   initial begin
      // Streaming at full rate from reset
      gnt_pct = 100; rv_pct = 100; rdy_pct = 100;
      do_reset();
      step(6);
      settle();
      p0 = n_pops;
      step(10);
      settle();
      chk("throughput", 32'(n_pops - p0), 32'd10);

      // Decode stalled: queue fills to DEPTH, then drains in order
      do_reset();
      rdy_pct = 0;
      step(12);
      settle();
      chk("full_req_low", 32'(imem_req), 32'd0);
      chk("full_valid", 32'(out_valid), 32'd1);
      rdy_pct = 100;
      step(12);

      // Two requests in flight, then redirect to an unaligned target
      do_reset();
      rv_pct = 0;
      step(3);
      settle();
      chk("max_outstanding_req", 32'(imem_req), 32'd0);
      rv_pct = 100;
      drive_cycle(1'b1, 1'b1, 32'h0000_4003);
      step(10);
      settle();
      chk("redir_first_pc", first_pc, 32'h0000_4000);

      // Redirect coinciding with a response and a pop
      do_reset();
      step(6);
      drive_cycle(1'b1, 1'b1, 32'h0000_5000);
      step(1);
      settle();
      chk("redir_empty_next", 32'(out_valid), 32'd0);
      step(8);

      // Address wrap at the top of memory
      drive_cycle(1'b1, 1'b1, 32'hFFFF_FFFC);
      step(10);
      settle();
      chk("wrap_first_pc", first_pc, 32'hFFFF_FFFC);

      // Reset while 3 entries are queued and 1 request is outstanding
      do_reset();
      rdy_pct = 0;
      hit = 1'b0;
      for (int i = 0; i < 40 && !hit; i++) begin
         step(1);
         settle();
         hit = (exp_q.size() == 3) && (mem_q.size() == 1);
      end
      chk("mid_reset_setup", 32'(hit), 32'd1);
      drive_cycle(1'b0, 1'b0, 32'd0);
      rdy_pct = 100;
      step(1);
      settle();
      chk("mid_reset_valid", 32'(out_valid), 32'd0);
      chk("mid_reset_addr", imem_addr, RESET_PC);
      step(10);

      // Randomized traffic with occasional redirects and resets
      for (int blk = 0; blk < 30; blk++) begin
         gnt_pct = $urandom_range(100, 20);
         rv_pct  = $urandom_range(100, 20);
         rdy_pct = $urandom_range(100, 10);
         for (int c = 0; c < 100; c++) begin
            if ($urandom_range(199) == 0) begin
               drive_cycle(1'b0, 1'b0, 32'd0);
            end else if ($urandom_range(99) < 3) begin
               drive_cycle(1'b1, 1'b1,
                           ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                                    : $urandom);
            end else begin
               step(1);
            end
         end
      end
      settle();

      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end

endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Instruction fetch front end that sits between the program-counter logic and the decode stage of the MIPS datapath. It owns a fetch address register (reset to 0x00003000), issues word reads to instruction memory over a request/grant/response handshake, and buffers returned instructions with their PCs in a small in-order queue for decode. A redirect (branch/jump/exception target) flushes the queue, discards in-flight responses, and restarts fetch at the new target.

## Interface
- RESET_PC, 32'h00003000: fetch address after reset.
- DEPTH, 4: queue entries (power of two, ≥2).
- MAX_OUTSTANDING, 2: maximum accepted-but-unanswered memory requests (1..3).

- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset. Sampled only on the rising edge of clk; the block resets while reset is 0.
- redirect  in  1  flush and restart fetch this cycle.
- redirect_pc  in  32  new fetch target; bits [1:0] are ignored and treated as 00.
- imem_req  out  1  read request valid.
- imem_addr  out  32  word-aligned read address.
- imem_gnt  in  1  request accepted when imem_req & imem_gnt.
- imem_rvalid  in  1  read data valid. Responses arrive in request order, at least 1 cycle after the grant.
- imem_rdata  in  32  instruction word.
- out_valid  out  1  queue head valid.
- out_ready  in  1  decode accepts the head; pop on out_valid & out_ready.
- out_instr  out  32  head instruction.
- out_pc  out  32  head instruction address.

## Operation
- State:
  - fetch_pc: next address to request.
  - resp_pc: PC of the next kept response.
  - outstanding: count of accepted requests not yet answered.
  - drop_cnt: responses still to discard.
  - FIFO of {pc, instr} with rd/wr pointers and a count.
- Reset values: fetch_pc = resp_pc = RESET_PC; outstanding = drop_cnt = 0; queue empty. Resulting outputs: out_valid = 0, out_instr = 0, out_pc = 0, imem_addr = RESET_PC.
- Credit: count + (outstanding − drop_cnt) < DEPTH and outstanding < MAX_OUTSTANDING.
- imem_req = credit & ~redirect. imem_addr = fetch_pc. Both are combinational from state and redirect.
- On grant: fetch_pc += 4, wrapping modulo 2^32. outstanding increments.
- On imem_rvalid: outstanding decrements.
  - If drop_cnt > 0 (or redirect is high this cycle): the response is discarded and drop_cnt decrements.
  - Otherwise: push {resp_pc, imem_rdata} and resp_pc += 4.
- Grant and response in the same cycle: outstanding is unchanged.
- On redirect:
  - Queue cleared, and any same-cycle pop is ignored.
  - fetch_pc = resp_pc = {redirect_pc[31:2], 2'b00}.
  - drop_cnt = outstanding − (same-cycle rvalid ? 1 : 0). Any response arriving in the redirect cycle is itself discarded.
  - No request is issued in the redirect cycle.
- Redirect while drop_cnt > 0: drop_cnt is recomputed from the total outstanding count, so old responses are never kept.
- Push and pop in the same cycle are both performed; count is unchanged.
- Overflow is impossible by the credit rule. A push into a full queue is a design error, flagged by a simulation assertion.
- Pop on an empty queue is ignored.

## Timing
- Reset: first request possible in the first cycle with reset = 1, at address RESET_PC.
- Back-to-back grants are allowed every cycle while credit holds.
- Response-to-output latency is 1 cycle: rvalid in cycle N gives out_valid in cycle N+1.
- Redirect in cycle N:
  - out_valid = 0 in N+1.
  - First request to the target in N+1.
  - First valid target instruction no earlier than 2 cycles after its grant.
- out_instr and out_pc are stable while out_valid = 1 and out_ready = 0.
- Reset asserted mid-operation:
  - All state returns to reset values at the next edge.
  - Responses from memory after reset are not dropped. The memory model must also be reset.

## Test plan
- Reset, then an imem model with gnt = 1 and 1-cycle rvalid latency, with out_ready = 1 → out_pc sequence 0x3000, 0x3004, 0x3008…, with the matching instr words. Sustained throughput of 1 instruction/cycle.
- out_ready = 0 held → exactly 4 entries buffered; imem_req drops once count + outstanding = 4. Releasing out_ready drains them in order 0x3000–0x300C, then fetch resumes at 0x3010.
- Two requests outstanding (0x3000, 0x3004), then redirect with redirect_pc = 0x00004003 → both old responses discarded. The first out_pc is 0x4000, followed by 0x4004.
- Redirect in the same cycle as imem_rvalid and out_ready/out_valid → that response is dropped, there is no pop side effect, and the queue is empty next cycle.
- Redirect to 0xFFFFFFFC → out_pc sequence 0xFFFFFFFC, then 0x00000000 (wrap).
- reset = 0 pulsed while the queue holds 3 entries and 1 request is outstanding → next cycle out_valid = 0 and imem_addr = 0x3000. Fetch restarts cleanly.
